// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for icache.
// The slave modport is the cache's view; master is the fetch stage plus memory controller.
interface icache_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        flush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iwait;
   logic [31:0] iload;
   logic        iREN;
   logic [31:0] iaddr;

   modport slave (
      input  imemREN, imemaddr, flush, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, flush, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-block instruction cache with blocking fill.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache #(
   parameter int SETS = 16
) (
   input logic      CLK,
   input logic      nRST,
   icache_if.slave  bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t            r_state, w_next_state;
   logic [SETS-1:0]   r_valid, w_valid_next;
   logic [TAG_W-1:0]  r_tag [SETS];
   logic [31:0]       r_data [SETS];
   logic [31:0]       r_miss_addr;

   logic [IDX_W-1:0]  w_idx, w_fill_idx;
   logic [TAG_W-1:0]  w_req_tag, w_fill_tag;
   logic              w_hit, w_miss, w_fill;
   logic              w_unused_offset;

   assign w_idx           = bus.imemaddr[IDX_W+1:2];
   assign w_req_tag       = bus.imemaddr[31:IDX_W+2];
   assign w_fill_idx      = r_miss_addr[IDX_W+1:2];
   assign w_fill_tag      = r_miss_addr[31:IDX_W+2];
   assign w_unused_offset = ^bus.imemaddr[1:0];

   // Flush masks a hit and suppresses a new miss in the same cycle.
   assign w_hit  = (r_state == IDLE) && bus.imemREN && !bus.flush &&
                   r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);
   assign w_miss = (r_state == IDLE) && bus.imemREN && !bus.flush && !w_hit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_miss_addr <= '0;
      end else begin
         r_state <= w_next_state;
         r_valid <= w_valid_next;
         if (w_miss)
            r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
      end
   end

   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= bus.iload;
      end
   end

   // A fill landing on a flush edge leaves its own frame valid.
   always_comb begin
      w_valid_next = bus.flush ? '0 : r_valid;
      if (w_fill)
         w_valid_next[w_fill_idx] = 1'b1;
   end

   always_comb begin
      w_next_state = r_state;
      w_fill       = 1'b0;
      bus.ihit     = 1'b0;
      bus.imemload = '0;
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      case (r_state)
         IDLE: begin
            bus.ihit = w_hit;
            if (w_hit)
               bus.imemload = r_data[w_idx];
            if (w_miss)
               w_next_state = FETCH;
         end
         FETCH: begin
            bus.iREN  = 1'b1;
            bus.iaddr = r_miss_addr;
            if (!bus.iwait) begin
               w_fill       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (bus.flush) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (w_hit && (hit_count != 32'hFFFF_FFFF))
            hit_count <= hit_count + 32'd1;
         if (w_miss && (miss_count != 32'hFFFF_FFFF))
            miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache: directed plan sequences then random traffic.
// Define ICACHE_STATS_EN to also check the counters.
module tb_icache;
   logic CLK;
   logic nRST;
   icache_if bus();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
   icache #(.SETS(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus),
                            .hit_count(hit_count), .miss_count(miss_count));
`else
   icache #(.SETS(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
`endif

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        ihit;
      logic [31:0] load;
      logic        ren;
      logic [31:0] addr;
      logic [31:0] hc;
      logic [31:0] mc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: 16 frames addressed by word number mod 16, tag = address / 64.
   bit          mv [16];
   logic [31:0] mt [16];
   logic [31:0] md [16];
   bit          m_pend;
   logic [31:0] m_pa;
   logic [31:0] m_hc, m_mc;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 4) % 16);
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      m_hc = 0;
      m_mc = 0;
   endtask

   task automatic cycle(input bit rst, input bit ren, input logic [31:0] a,
                        input bit fl, input bit wt, input logic [31:0] ld);
      exp_t e;
      int   ix;
      bit   hit;
      @(negedge CLK);
      nRST         = !rst;
      bus.imemREN  = ren;
      bus.imemaddr = a;
      bus.flush    = fl;
      bus.iwait    = wt;
      bus.iload    = ld;
      e.hc = m_hc;
      e.mc = m_mc;
      if (rst) begin
         e.ihit = 0; e.load = 0; e.ren = 0; e.addr = 0; e.hc = 0; e.mc = 0;
         model_clear();
         m_pend = 0;
      end else if (m_pend) begin
         e.ihit = 0; e.load = 0; e.ren = 1; e.addr = m_pa;
         if (fl) model_clear();
         if (!wt) begin
            ix = idx_of(m_pa);
            mv[ix] = 1; mt[ix] = m_pa / 64; md[ix] = ld;
            m_pend = 0;
         end
      end else begin
         ix  = idx_of(a);
         hit = ren && !fl && mv[ix] && (mt[ix] == a / 64);
         e.ihit = hit; e.load = hit ? md[ix] : 32'h0; e.ren = 0; e.addr = 0;
         if (fl) model_clear();
         else begin
            if (hit && m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
            if (ren && !hit) begin
               m_pend = 1;
               m_pa   = a & ~32'h3;
               if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic req(input logic [31:0] a, input bit wt, input logic [31:0] ld);
      cycle(0, 1, a, 0, wt, ld);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.ihit !== e.ihit || bus.imemload !== e.load ||
                bus.iREN !== e.ren || bus.iaddr !== e.addr) begin
               errors++;
               $display("FAIL outputs t=%0t: got ihit=%b imemload=%h iREN=%b iaddr=%h, want ihit=%b imemload=%h iREN=%b iaddr=%h",
                        $time, bus.ihit, bus.imemload, bus.iREN, bus.iaddr,
                        e.ihit, e.load, e.ren, e.addr);
            end
`ifdef ICACHE_STATS_EN
            checks++;
            if (hit_count !== e.hc || miss_count !== e.mc) begin
               errors++;
               $display("FAIL stats t=%0t: got hit_count=%0d miss_count=%0d, want %0d %0d",
                        $time, hit_count, miss_count, e.hc, e.mc);
            end
`endif
         end
      end
   end

   initial begin
      bit          ren, fl, wt, rst;
      logic [31:0] a, ld;
      nRST = 1'b0;
      bus.imemREN = 0; bus.imemaddr = 0; bus.flush = 0; bus.iwait = 1; bus.iload = 0;
      model_clear();
      m_pend = 0; m_pa = 0;
      cycle(1, 0, 0, 0, 1, 0);
      cycle(1, 1, 0, 0, 1, 0);

      // Cold miss on 0x0, two wait cycles, then fill; then hit at offset 2.
      req(32'h0, 1, 0);
      req(32'h0, 1, 0);
      req(32'h0, 1, 0);
      req(32'h0, 0, 32'h2001_0005);
      req(32'h0, 1, 0);
      req(32'h2, 1, 0);

      // Conflict on index 0.
      req(32'h40, 1, 0);
      req(32'h40, 0, 32'hDEAD_BEEF);
      req(32'h40, 1, 0);
      req(32'h0, 1, 0);
      req(32'h0, 0, 32'h2001_0005);
      req(32'h0, 1, 0);

      // Redirect during fill.
      req(32'h100, 1, 0);
      req(32'h200, 1, 0);
      cycle(0, 0, 32'h200, 0, 1, 0);
      req(32'h200, 0, mem_word(32'h100));
      req(32'h200, 1, 0);
      req(32'h200, 0, mem_word(32'h200));
      req(32'h200, 1, 0);
      req(32'h100, 1, 0);

      // Flush in IDLE, then flush coincident with a fill at 0x4.
      cycle(0, 1, 32'h0, 1, 1, 0);
      req(32'h0, 1, 0);
      req(32'h0, 0, 32'h2001_0005);
      req(32'h4, 1, 0);
      cycle(0, 1, 32'h4, 1, 0, 32'h1234_5678);
      req(32'h4, 1, 0);

      // Reset during FETCH, then a previously filled address misses.
      req(32'h8, 1, 0);
      req(32'h8, 1, 0);
      cycle(1, 1, 32'h8, 0, 1, 0);
      req(32'h4, 1, 0);
      req(32'h4, 0, 32'h1234_5678);
      req(32'h4, 1, 0);

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         ren = ($urandom_range(0, 99) < 85);
         fl  = ($urandom_range(0, 99) < 3);
         wt  = ($urandom_range(0, 99) < 50);
         a   = ($urandom_range(0, 99) < 90) ? (32'($urandom_range(0, 63)) << 2) : $urandom;
         a   = a | 32'($urandom_range(0, 3));
         ld  = (m_pend && !wt) ? mem_word(m_pa) : $urandom;
         cycle(rst, ren, a, fl, wt, ld);
      end

      @(negedge CLK);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
